bsg_contract_bitmask: RTL and testbench
=======================================

Name: bsg_contract_bitmask

Overview:
- Inverse of the bitmask expander: collapses each group of expand_p adjacent input bits into one output bit. For expand_p=2, 8-bit masks become 4-bit masks.
- Streaming block with a valid/ready handshake on both sides and a 2-entry output buffer.
- Checks that every group is uniform (all 0s or all 1s) and flags any group that is not.
- Sits between a byte/word-granular mask producer and a coarser-granular consumer, for example write-mask narrowing in the cache/memory path.

Parameters:
- in_width_p, 8, input mask width; must be a nonzero multiple of expand_p.
- expand_p, 2, bits per group; out width is in_width_p/expand_p (default 4).
- reduce_and_p, 0, group reduction: 0 = OR of group bits, 1 = AND of group bits.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- i  in  in_width_p  input mask.
- v_i  in  1  input valid.
- ready_o  out  1  block can accept input.
- o  out  in_width_p/expand_p  contracted mask at the buffer head.
- mismatch_o  out  1  head entry had at least one non-uniform group.
- v_o  out  1  output valid.
- ready_i  in  1  consumer accepts.
- err_o  out  1  sticky error; set by any accepted non-uniform input.
- clear_err_i  in  1  clears err_o.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - buffer empty, v_o=0, o=0, mismatch_o=0, err_o=0, ready_o=1.
  - Reset mid-stream discards all buffered entries.
- Contraction, group g = i[g*expand_p +: expand_p]:
  - reduced bit = OR(group) when reduce_and_p=0, AND(group) when reduce_and_p=1.
  - group mismatch = group is neither all-0 nor all-1.
  - Entry = {mismatch = OR of all group mismatches, data = reduced bits}.
  - All of this is computed combinationally from i; nothing is registered before the buffer.
- Handshake:
  - Enqueue when v_i & ready_o. Dequeue when v_o & ready_i.
  - i is ignored when v_i=0.
- Buffer: 2-entry FIFO with count 0..2.
  - ready_o = (count != 2). It is a registered/state-derived signal with no combinational path from ready_i.
  - v_o = (count != 0).
  - o and mismatch_o show the head entry; they hold value when v_o=0, with o=0 after reset.
- Latency: an accepted input appears on o at the next rising edge (1 cycle). No bypass path.
- Count transitions:
  - enqueue only: +1.
  - dequeue only: -1.
  - enqueue and dequeue together with count=1: count stays 1, head advances to the new entry.
  - enqueue and dequeue together with count=0: not possible, because v_o=0.
  - count=2: ready_o=0, so no enqueue; a dequeue takes count to 1.
- Ordering: strict FIFO; entries are never dropped or reordered.
- err_o:
  - set on the edge after accepting an entry with mismatch=1.
  - cleared on the edge where clear_err_i=1.
  - if set and clear occur in the same cycle, set wins (err_o=1).
- Width rules: in_width_p % expand_p != 0 is illegal; simulation flags it with an error at elaboration time.

Optional Feature:
- Macro: BSG_CONTRACT_BITMASK_ERR_CNT_EN.
- When defined:
  - adds output port err_cnt_o, 8 bits: saturating count of accepted mismatching inputs, 0 at reset.
  - increments by 1 per accepted mismatching input and saturates at 255.
  - clear_err_i also zeroes err_cnt_o. If increment and clear occur in the same cycle, result is 1.
- When not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, reset, then one input i=8'b1100_0011 with v_i=1 and ready_i=1.
  -> next cycle: v_o=1, o=4'b1001, mismatch_o=0, err_o=0; v_o=0 afterwards.
- i=8'b0000_0110, reduce_and_p=0.
  -> o=4'b0011, mismatch_o=1, err_o=1 and stays 1.
  -> assert clear_err_i for one cycle -> err_o=0.
  -> with the same cycle also accepting a mismatching input -> err_o remains 1.
- reduce_and_p=1, i=8'b0110_1111 -> o=4'b0011, mismatch_o=1.
- Backpressure: ready_i=0, present 8'hFF, 8'h00, 8'h0F.
  -> first two accepted; ready_o=0 at count=2; third held.
  -> ready_i=1 -> outputs 4'hF, 4'h0, 4'h3 in order, one per cycle, no loss.
- Streaming: v_i=1 and ready_i=1 continuously for 16 inputs.
  -> count stays 1, ready_o stays 1, one output per cycle, 1-cycle latency.
- Reset asserted asynchronously with count=2 -> v_o=0, ready_o=1, o=0, err_o=0 immediately, before the next edge.
- With BSG_CONTRACT_BITMASK_ERR_CNT_EN: 300 mismatching inputs -> err_cnt_o=255. Then clear_err_i -> err_cnt_o=0.

Source files
------------

// File: rtl/bsg_contract_bitmask_if.sv
// Mask stream interface for bsg_contract_bitmask.
// The producer drives i/v_i and sees ready_o. The consumer sees o/mismatch_o/v_o and drives ready_i.
interface bsg_contract_bitmask_if #(
  parameter int unsigned in_width_p = 8,
  parameter int unsigned expand_p   = 2
);
  localparam int unsigned OutWidth = in_width_p / expand_p;

  logic [in_width_p-1:0] i;
  logic                  v_i;
  logic                  ready_o;
  logic [OutWidth-1:0]   o;
  logic                  mismatch_o;
  logic                  v_o;
  logic                  ready_i;

  // Block side
  modport slave (
    input  i, v_i, ready_i,
    output ready_o, o, mismatch_o, v_o
  );

  // Producer/consumer side
  modport master (
    output i, v_i, ready_i,
    input  ready_o, o, mismatch_o, v_o
  );
endinterface

// File: rtl/bsg_contract_bitmask.sv
// Bitmask contractor. Each group of expand_p adjacent input bits collapses to one output bit,
// using OR or AND as set by reduce_and_p. Any group that is not uniform raises a mismatch flag.
// A 2-entry FIFO sits on the output side. err_o is a sticky error flag.
// Optional feature: define BSG_CONTRACT_BITMASK_ERR_CNT_EN to add err_cnt_o. This is a saturating
// 8-bit count of accepted mismatching inputs.
module bsg_contract_bitmask #(
  parameter int unsigned in_width_p   = 8,
  parameter int unsigned expand_p     = 2,
  parameter int unsigned reduce_and_p = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bsg_contract_bitmask_if.slave bus_io,
  output logic                  err_o,
  input  logic                  clear_err_i
`ifdef BSG_CONTRACT_BITMASK_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt_o
`endif
);

  localparam int unsigned OutWidth = in_width_p / expand_p;

  if (expand_p == 0 || (in_width_p % expand_p) != 0) begin : g_bad_width
    $error("bsg_contract_bitmask: in_width_p must be a nonzero multiple of expand_p");
  end

  logic [OutWidth-1:0] red_data;
  logic                red_mis;
  logic [expand_p-1:0] grp;

  // Per-group reduction and uniformity check, purely combinational from the input
  always_comb begin
    red_data = '0;
    red_mis  = 1'b0;
    grp      = '0;
    for (int g = 0; g < int'(OutWidth); g++) begin
      grp         = bus_io.i[g*expand_p +: expand_p];
      red_data[g] = (reduce_and_p != 0) ? &grp : |grp;
      red_mis     = red_mis | ((|grp) & ~(&grp));
    end
  end

  logic [1:0]          count_q, count_d;
  logic [OutWidth-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic                head_mis_q, head_mis_d, tail_mis_q, tail_mis_d;
  logic                err_q, err_d;
  logic                enq, deq;

  assign bus_io.ready_o    = (count_q != 2'd2);
  assign bus_io.v_o        = (count_q != 2'd0);
  assign bus_io.o          = head_data_q;
  assign bus_io.mismatch_o = head_mis_q;
  assign err_o             = err_q;

  assign enq = bus_io.v_i & bus_io.ready_o;
  assign deq = bus_io.v_o & bus_io.ready_i;

  // FIFO next state. The head register holds its value once the FIFO empties.
  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_mis_d  = head_mis_q;
    tail_data_d = tail_data_q;
    tail_mis_d  = tail_mis_q;
    if (enq && !deq) begin
      count_d = count_q + 2'd1;
      if (count_q == 2'd0) begin
        head_data_d = red_data;
        head_mis_d  = red_mis;
      end else begin
        tail_data_d = red_data;
        tail_mis_d  = red_mis;
      end
    end else if (deq && !enq) begin
      count_d = count_q - 2'd1;
      if (count_q == 2'd2) begin
        head_data_d = tail_data_q;
        head_mis_d  = tail_mis_q;
      end
    end else if (enq && deq) begin
      // Only reachable with count 1: the new entry replaces the departing head
      head_data_d = red_data;
      head_mis_d  = red_mis;
    end
  end

  // Sticky error: when set and clear coincide, set wins
  always_comb begin
    err_d = err_q;
    if (clear_err_i)      err_d = 1'b0;
    if (enq && red_mis)   err_d = 1'b1;
  end

  // FIFO and error state
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_mis_q  <= 1'b0;
      tail_data_q <= '0;
      tail_mis_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_mis_q  <= head_mis_d;
      tail_data_q <= tail_data_d;
      tail_mis_q  <= tail_mis_d;
      err_q       <= err_d;
    end
  end

`ifdef BSG_CONTRACT_BITMASK_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count. An increment in the same cycle as a clear leaves the count at 1.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear_err_i) err_cnt_d = 8'd0;
    if (enq && red_mis) begin
      if (clear_err_i)              err_cnt_d = 8'd1;
      else if (err_cnt_q != 8'hff)  err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter state
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_cnt_q <= 8'd0;
    else            err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_bsg_contract_bitmask.sv
// Testbench for bsg_contract_bitmask. A scoreboard queue models the output FIFO.
// A second instance with reduce_and_p=1 covers the AND reduction.
module tb_bsg_contract_bitmask;

  typedef struct packed {
    logic       mis;
    logic [3:0] data;
  } ent_t;

  logic clk, reset_n;
  logic clear_err, clear_err_a;
  logic err, err_a;
`ifdef BSG_CONTRACT_BITMASK_ERR_CNT_EN
  logic [7:0] err_cnt, err_cnt_a;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  ent_t q[$];

  bsg_contract_bitmask_if #(.in_width_p(8), .expand_p(2)) bus ();
  bsg_contract_bitmask_if #(.in_width_p(8), .expand_p(2)) bus_a ();

  bsg_contract_bitmask #(.in_width_p(8), .expand_p(2), .reduce_and_p(0)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .bus_io      (bus.slave),
    .err_o       (err),
    .clear_err_i (clear_err)
`ifdef BSG_CONTRACT_BITMASK_ERR_CNT_EN
    ,
    .err_cnt_o   (err_cnt)
`endif
  );

  bsg_contract_bitmask #(.in_width_p(8), .expand_p(2), .reduce_and_p(1)) dut_and (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .bus_io      (bus_a.slave),
    .err_o       (err_a),
    .clear_err_i (clear_err_a)
`ifdef BSG_CONTRACT_BITMASK_ERR_CNT_EN
    ,
    .err_cnt_o   (err_cnt_a)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t model(input logic [7:0] v, input bit and_mode);
    ent_t       e;
    logic [1:0] p;
    e = '0;
    for (int g = 0; g < 4; g++) begin
      p         = v[2*g +: 2];
      e.data[g] = and_mode ? (p == 2'b11) : (p != 2'b00);
      if (p == 2'b01 || p == 2'b10) e.mis = 1'b1;
    end
    return e;
  endfunction

  // One clock. Handshakes are judged at the negedge, when they are stable before the edge.
  task automatic step();
    ent_t e;
    @(negedge clk);
    if (bus.v_o && bus.ready_i) begin
      if (q.size() == 0) begin
        check("sb_underflow", 32'(q.size()), 32'(1));
      end else begin
        e = q.pop_front();
        check("sb_o", 32'(bus.o), 32'(e.data));
        check("sb_mismatch", 32'(bus.mismatch_o), 32'(e.mis));
      end
    end
    if (bus.v_i && bus.ready_o) q.push_back(model(bus.i, 1'b0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    ent_t ea;
    reset_n     = 1'b0;
    clear_err   = 1'b0;
    clear_err_a = 1'b0;
    bus.i       = '0;
    bus.v_i     = 1'b0;
    bus.ready_i = 1'b1;
    bus_a.i       = '0;
    bus_a.v_i     = 1'b0;
    bus_a.ready_i = 1'b1;
    #12;
    check("rst_ready_o", 32'(bus.ready_o), 32'(1));
    check("rst_v_o", 32'(bus.v_o), 32'(0));
    check("rst_o", 32'(bus.o), 32'(0));
    check("rst_mismatch", 32'(bus.mismatch_o), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single uniform input: 1-cycle latency, then empty
    bus.i   = 8'b1100_0011;
    bus.v_i = 1'b1;
    step();
    bus.v_i = 1'b0;
    check("first_v_o", 32'(bus.v_o), 32'(1));
    check("first_o", 32'(bus.o), 32'(4'b1001));
    check("first_mis", 32'(bus.mismatch_o), 32'(0));
    check("first_err", 32'(err), 32'(0));
    step();
    check("first_v_o_after", 32'(bus.v_o), 32'(0));

    // Mismatching input sets sticky err_o
    bus.i   = 8'b0000_0110;
    bus.v_i = 1'b1;
    step();
    bus.v_i = 1'b0;
    check("mis_o", 32'(bus.o), 32'(4'b0011));
    check("mis_flag", 32'(bus.mismatch_o), 32'(1));
    check("err_set", 32'(err), 32'(1));
    step();
    step();
    check("err_sticky", 32'(err), 32'(1));
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("err_clear", 32'(err), 32'(0));
    // Clear and set in the same cycle: set wins
    clear_err = 1'b1;
    bus.v_i   = 1'b1;
    step();
    clear_err = 1'b0;
    bus.v_i   = 1'b0;
    check("err_set_wins", 32'(err), 32'(1));
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("err_clear2", 32'(err), 32'(0));

    // AND reduction on the second instance
    bus_a.i   = 8'b0110_1111;
    bus_a.v_i = 1'b1;
    ea        = model(8'b0110_1111, 1'b1);
    step();
    bus_a.v_i = 1'b0;
    check("and_v_o", 32'(bus_a.v_o), 32'(1));
    check("and_o", 32'(bus_a.o), 32'(ea.data));
    check("and_o_const", 32'(bus_a.o), 32'(4'b0011));
    check("and_mis", 32'(bus_a.mismatch_o), 32'(1));

    // Backpressure: two accepted, third held until the consumer drains
    bus.ready_i = 1'b0;
    bus.v_i     = 1'b1;
    bus.i       = 8'hff;
    step();
    bus.i = 8'h00;
    step();
    bus.i = 8'h0f;
    check("bp_ready_full", 32'(bus.ready_o), 32'(0));
    step();
    check("bp_ready_held", 32'(bus.ready_o), 32'(0));
    check("bp_head", 32'(bus.o), 32'(4'hf));
    check("bp_queue", 32'(q.size()), 32'(2));
    bus.ready_i = 1'b1;
    step();
    step();
    bus.v_i = 1'b0;
    step();
    check("bp_drained", 32'(bus.v_o), 32'(0));
    check("bp_sb_empty", 32'(q.size()), 32'(0));

    // Streaming: count stays at 1
    bus.v_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.i = 8'($urandom);
      step();
      check("stream_ready", 32'(bus.ready_o), 32'(1));
      check("stream_v_o", 32'(bus.v_o), 32'(1));
    end
    bus.v_i = 1'b0;
    step();
    check("stream_sb_empty", 32'(q.size()), 32'(0));
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;

    // Asynchronous reset while full and flagged
    bus.ready_i = 1'b0;
    bus.v_i     = 1'b1;
    bus.i       = 8'b0000_0110;
    step();
    bus.i = 8'b1100_1100;
    step();
    bus.v_i = 1'b0;
    check("ar_full", 32'(bus.ready_o), 32'(0));
    check("ar_err_pre", 32'(err), 32'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_v_o", 32'(bus.v_o), 32'(0));
    check("ar_ready_o", 32'(bus.ready_o), 32'(1));
    check("ar_o", 32'(bus.o), 32'(0));
    check("ar_err", 32'(err), 32'(0));
    q.delete();
    @(negedge clk);
    reset_n     = 1'b1;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;

`ifdef BSG_CONTRACT_BITMASK_ERR_CNT_EN
    check("cnt_rst", 32'(err_cnt), 32'(0));
    bus.v_i = 1'b1;
    bus.i   = 8'b1000_0000;
    for (int k = 0; k < 300; k++) step();
    bus.v_i = 1'b0;
    step();
    check("cnt_sat", 32'(err_cnt), 32'(255));
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("cnt_clear", 32'(err_cnt), 32'(0));
    bus.v_i   = 1'b1;
    step();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    bus.v_i   = 1'b0;
    check("cnt_clear_inc", 32'(err_cnt), 32'(1));
    step();
`endif

    check("end_sb_empty", 32'(q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
